xgmii_rx_frame_checker: RTL
===========================

Name: xgmii_rx_frame_checker

Overview:
- Synthesizable checker on the receive side of the 10GBASE-R loopback path, in the clk_156 domain.
- Consumes the 64-bit XGMII receive stream (baserRx side) and parses frames.
- Checks each frame against the incrementing-byte payload and length rules that the transmit-side generator uses.
- Reports per-frame pass/fail pulses with an error code, plus saturating good/bad frame counters for test and status readout.

Parameters:
- DATA_WIDTH, 64, XGMII data width; fixed at 64 (8 lanes, lane 0 = bits 7:0).
- CNT_WIDTH, 32, width of ok_cnt/err_cnt.
- MIN_LEN, 64, minimum frame length in bytes (SFD excluded, terminate excluded).
- MAX_LEN, 1518, maximum frame length in bytes.

Ports:
- clk_156  input  1  156.25 MHz XGMII clock.
- rst_156  input  1  asynchronous active-high reset.
- xgmii_rxd  input  64  XGMII receive data; lane n = bits 8n+7:8n.
- xgmii_rxc  input  8  XGMII receive control; bit n marks lane n as control.
- clr_cnt  input  1  synchronous clear of ok_cnt and err_cnt.
- in_frame  output  1  high while in PAYLOAD state.
- frame_ok  output  1  one-cycle pulse: frame passed all checks.
- frame_err  output  1  one-cycle pulse: frame failed.
- err_code  output  3  code of the first error in the failed frame; valid with frame_err.
- ok_cnt  output  CNT_WIDTH  saturating count of good frames.
- err_cnt  output  CNT_WIDTH  saturating count of bad frames.

Behaviour:
- Reset (async assert, release on a clk_156 edge): state IDLE. All outputs 0, byte counter 0, latched error 0.
- Start word:
  - rxc=8'h01, lane0=8'hFB, lanes1-6=8'h55, lane7=8'hD5.
  - Any other word with lane0 control FB is a start with bad preamble: enter PAYLOAD with err latched to 5.
- Start detected in lane 4 (rxc[4]=1, lane4=FB): err 7 reported immediately, no frame opened.
- States:
  - IDLE -> PAYLOAD on a start word. Every other word in IDLE is ignored, including stray terminates.
  - PAYLOAD: all 8 lanes must be data (rxc=0). Byte k of the frame must equal k[7:0]; k starts at 0 and counts across words. byte_cnt increments by the number of data lanes, 16 bits, saturating at 16'hFFFF.
  - PAYLOAD -> IDLE on a terminate word.
- Terminate word: first lane i with rxc[i]=1 and value FD.
  - Lanes below i are checked as payload data.
  - Lanes above i must be control 07, otherwise err 4.
  - i=0 means 0 data bytes in that word.
- Error codes (first detected within a frame is latched; later errors do not overwrite):
  - 1: pattern mismatch.
  - 2: length < MIN_LEN.
  - 3: length > MAX_LEN.
  - 4: any other control character in PAYLOAD, including FE error, non-FD control, or bad post-terminate fill.
  - 5: bad preamble.
  - 6: start word while in PAYLOAD. The old frame is reported as err 6 and a new frame opens in the same cycle.
  - 7: misaligned start.
- Length checks are evaluated at terminate and apply only if no earlier error is latched.
- Reporting latency: frame_ok/frame_err assert in the cycle after the terminate (or aborting start) word is sampled. They are never both high.
- err_code holds its last value until the next frame_err.
- Counters:
  - Increment on frame_ok / frame_err, saturate at all ones.
  - clr_cnt has priority: a coincident event is not counted, so the result is 0.
- Reset mid-frame: frame discarded, nothing reported.

Test Plan:
- 64-byte frame (start, 8 data words of 00..3F, terminate word rxc=FF lane0 FD, lanes 1-7 = 07) -> frame_ok 1 cycle after terminate, ok_cnt=1, err_cnt=0.
- 67-byte frame, terminate in lane 3 of last word with lanes 4-7 = 07 -> frame_ok; byte 66 value checked as 8'h42.
- Frame with byte 10 = 8'hAA instead of 8'h0A, length 100 -> frame_err, err_code=1, err_cnt=1, ok_cnt unchanged.
- 40-byte frame -> err_code=2.
- 1600-byte frame -> err_code=3.
- Second start word after 3 payload words -> frame_err err_code=6 next cycle, in_frame stays 1; new frame of 64 bytes then gives frame_ok.
- ok_cnt preset to all ones by 2^CNT_WIDTH frames (bench uses CNT_WIDTH=4: 16 frames), 17th good frame -> ok_cnt stays 4'hF.
- clr_cnt asserted in the same cycle as frame_ok -> ok_cnt=0.
- Assert rst_156 asynchronously mid-PAYLOAD -> outputs 0 immediately, no pulse after release.

Source files
------------

// File: rtl/xgmii_rx_frame_checker.sv
// Receive-side XGMII frame checker: parses frames from the 64-bit stream, checks the
// incrementing-byte payload and length limits, and keeps saturating good/bad frame counters.
module xgmii_rx_frame_checker #(
    parameter int DATA_WIDTH = 64,
    parameter int CNT_WIDTH  = 32,
    parameter int MIN_LEN    = 64,
    parameter int MAX_LEN    = 1518
) (
    input  logic                  clk_156,
    input  logic                  rst_156,
    input  logic [DATA_WIDTH-1:0] xgmii_rxd,
    input  logic [7:0]            xgmii_rxc,
    input  logic                  clr_cnt,
    output logic                  in_frame,
    output logic                  frame_ok,
    output logic                  frame_err,
    output logic [2:0]            err_code,
    output logic [CNT_WIDTH-1:0]  ok_cnt,
    output logic [CNT_WIDTH-1:0]  err_cnt
);
    localparam logic [7:0] C_START = 8'hFB;
    localparam logic [7:0] C_TERM  = 8'hFD;
    localparam logic [7:0] C_IDLE  = 8'h07;

    localparam logic [2:0] C_ERR_NONE    = 3'd0;
    localparam logic [2:0] C_ERR_PAT     = 3'd1;
    localparam logic [2:0] C_ERR_SHORT   = 3'd2;
    localparam logic [2:0] C_ERR_LONG    = 3'd3;
    localparam logic [2:0] C_ERR_CTRL    = 3'd4;
    localparam logic [2:0] C_ERR_PRE     = 3'd5;
    localparam logic [2:0] C_ERR_RESTART = 3'd6;
    localparam logic [2:0] C_ERR_ALIGN   = 3'd7;

    localparam logic [CNT_WIDTH-1:0] C_CNT_MAX = {CNT_WIDTH{1'b1}};

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_PAYLOAD = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [15:0]          r_byte_cnt;
    logic [15:0]          w_byte_cnt_nxt;
    logic [2:0]           r_err;
    logic [2:0]           w_err_nxt;
    logic                 r_frame_ok;
    logic                 w_frame_ok_nxt;
    logic                 r_frame_err;
    logic                 w_frame_err_nxt;
    logic [2:0]           r_err_code;
    logic [2:0]           w_err_code_nxt;
    logic [CNT_WIDTH-1:0] r_ok_cnt;
    logic [CNT_WIDTH-1:0] r_err_cnt;

    logic        w_is_start;
    logic        w_pre_ok;
    logic        w_misaligned;
    logic [2:0]  w_new_err;
    logic [3:0]  w_term_idx;
    logic        w_term_hit;
    logic [2:0]  w_lane_err;
    logic [2:0]  w_word_err;
    logic [3:0]  w_data_lanes;
    logic [16:0] w_cnt_sum;
    logic [15:0] w_cnt_sat;
    logic [2:0]  w_first_err;
    logic [2:0]  w_final_err;

    assign w_is_start   = xgmii_rxc[0] && (xgmii_rxd[7:0] == C_START);
    assign w_pre_ok     = (xgmii_rxc == 8'h01) && (xgmii_rxd[63:8] == 56'hD5_5555_5555_5555);
    assign w_misaligned = xgmii_rxc[4] && (xgmii_rxd[39:32] == C_START);
    assign w_new_err    = w_pre_ok ? C_ERR_NONE : C_ERR_PRE;

    // Locate the lowest lane holding a terminate; index 8 means the word has none.
    always_comb begin
        w_term_idx = 4'd8;
        for (int i = 7; i >= 0; i--) begin
            w_term_idx = (xgmii_rxc[i] && (xgmii_rxd[8*i +: 8] == C_TERM)) ? 4'(i) : w_term_idx;
        end
    end

    assign w_term_hit = (w_term_idx != 4'd8);

    // Per-lane checks; the lowest failing lane decides the error for the word.
    always_comb begin
        w_word_err   = C_ERR_NONE;
        w_lane_err   = C_ERR_NONE;
        w_data_lanes = 4'd0;
        for (int j = 0; j < 8; j++) begin
            if (4'(j) < w_term_idx) begin
                w_lane_err   = xgmii_rxc[j] ? C_ERR_CTRL :
                               (xgmii_rxd[8*j +: 8] != (r_byte_cnt[7:0] + 8'(j))) ? C_ERR_PAT :
                               C_ERR_NONE;
                w_data_lanes = w_data_lanes + {3'd0, ~xgmii_rxc[j]};
            end else if (4'(j) > w_term_idx) begin
                w_lane_err = (xgmii_rxc[j] && (xgmii_rxd[8*j +: 8] == C_IDLE)) ? C_ERR_NONE
                                                                              : C_ERR_CTRL;
            end else begin
                w_lane_err = C_ERR_NONE;
            end
            w_word_err = (w_word_err != C_ERR_NONE) ? w_word_err : w_lane_err;
        end
    end

    assign w_cnt_sum   = {1'b0, r_byte_cnt} + {13'd0, w_data_lanes};
    assign w_cnt_sat   = w_cnt_sum[16] ? 16'hFFFF : w_cnt_sum[15:0];
    assign w_first_err = (r_err != C_ERR_NONE) ? r_err : w_word_err;
    // Length limits only matter when nothing earlier in the frame has already failed.
    assign w_final_err = (w_first_err != C_ERR_NONE)  ? w_first_err :
                         (w_cnt_sat < 16'(MIN_LEN))   ? C_ERR_SHORT :
                         (w_cnt_sat > 16'(MAX_LEN))   ? C_ERR_LONG  : C_ERR_NONE;

    // Next-state, byte count, latched error and report pulses.
    always_comb begin
        w_state_nxt     = r_state;
        w_byte_cnt_nxt  = r_byte_cnt;
        w_err_nxt       = r_err;
        w_frame_ok_nxt  = 1'b0;
        w_frame_err_nxt = 1'b0;
        w_err_code_nxt  = r_err_code;
        case (r_state)
            S_IDLE: begin
                if (w_is_start) begin
                    w_state_nxt    = S_PAYLOAD;
                    w_byte_cnt_nxt = 16'd0;
                    w_err_nxt      = w_new_err;
                end else if (w_misaligned) begin
                    w_frame_err_nxt = 1'b1;
                    w_err_code_nxt  = C_ERR_ALIGN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_PAYLOAD: begin
                if (w_is_start) begin
                    w_frame_err_nxt = 1'b1;
                    w_err_code_nxt  = (r_err != C_ERR_NONE) ? r_err : C_ERR_RESTART;
                    w_byte_cnt_nxt  = 16'd0;
                    w_err_nxt       = w_new_err;
                end else if (w_term_hit) begin
                    w_state_nxt     = S_IDLE;
                    w_byte_cnt_nxt  = 16'd0;
                    w_err_nxt       = C_ERR_NONE;
                    w_frame_ok_nxt  = (w_final_err == C_ERR_NONE);
                    w_frame_err_nxt = (w_final_err != C_ERR_NONE);
                    w_err_code_nxt  = (w_final_err != C_ERR_NONE) ? w_final_err : r_err_code;
                end else begin
                    w_byte_cnt_nxt = w_cnt_sat;
                    w_err_nxt      = w_first_err;
                end
            end
            default: begin
                w_state_nxt    = S_IDLE;
                w_byte_cnt_nxt = 16'd0;
                w_err_nxt      = C_ERR_NONE;
            end
        endcase
    end

    // Frame state and report registers.
    always_ff @(posedge clk_156 or posedge rst_156) begin
        if (rst_156) begin
            r_state     <= S_IDLE;
            r_byte_cnt  <= 16'd0;
            r_err       <= C_ERR_NONE;
            r_frame_ok  <= 1'b0;
            r_frame_err <= 1'b0;
            r_err_code  <= C_ERR_NONE;
        end else begin
            r_state     <= w_state_nxt;
            r_byte_cnt  <= w_byte_cnt_nxt;
            r_err       <= w_err_nxt;
            r_frame_ok  <= w_frame_ok_nxt;
            r_frame_err <= w_frame_err_nxt;
            r_err_code  <= w_err_code_nxt;
        end
    end

    // Saturating counters; a clear wins over a coincident frame event.
    always_ff @(posedge clk_156 or posedge rst_156) begin
        if (rst_156) begin
            r_ok_cnt  <= {CNT_WIDTH{1'b0}};
            r_err_cnt <= {CNT_WIDTH{1'b0}};
        end else if (clr_cnt) begin
            r_ok_cnt  <= {CNT_WIDTH{1'b0}};
            r_err_cnt <= {CNT_WIDTH{1'b0}};
        end else begin
            r_ok_cnt  <= (r_frame_ok && (r_ok_cnt != C_CNT_MAX))
                         ? r_ok_cnt + CNT_WIDTH'(1) : r_ok_cnt;
            r_err_cnt <= (r_frame_err && (r_err_cnt != C_CNT_MAX))
                         ? r_err_cnt + CNT_WIDTH'(1) : r_err_cnt;
        end
    end

    assign in_frame  = (r_state == S_PAYLOAD);
    assign frame_ok  = r_frame_ok;
    assign frame_err = r_frame_err;
    assign err_code  = r_err_code;
    assign ok_cnt    = r_ok_cnt;
    assign err_cnt   = r_err_cnt;

endmodule
